// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the APB timer count-enable path:
//   - cnt_ctrl_state_e : controller FSM states (IDLE, RUN, HALTED)
//   - PRESCALE_W       : default prescaler counter width
//   - MAX_DIV_VAL      : default largest legal divisor exponent
//   - div_exp_t        : 4-bit divisor exponent (divisor = 2^exp)
//   - div_cfg_illegal  : flags an out-of-range exponent while the prescaler
//                        is enabled
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int unsigned PRESCALE_W  = 8;
    localparam int unsigned MAX_DIV_VAL = 8;

    typedef logic [3:0] div_exp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } cnt_ctrl_state_e;

    // An exponent above the supported maximum only matters when the
    // prescaler is actually in use.
    function automatic logic div_cfg_illegal(input logic        div_en,
                                             input div_exp_t    div_val,
                                             input int unsigned max_val);
        return div_en && ({28'd0, div_val} > max_val);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Power-of-two prescaler for the timer count-enable path. Counts run cycles,
// compares against the terminal value (2^div_val - 1, or 0 when the prescaler
// is disabled) and emits a registered single-cycle tick on wrap.
//
// Ports:
//   i_clk      in  1  system clock, rising edge
//   i_rst_n    in  1  asynchronous active-low reset
//   i_run      in  1  advance the counter on this edge
//   i_freeze   in  1  hold the counter (ignored when i_run is high)
//   i_clear    in  1  force the counter to 0, no tick
//   i_div_en   in  1  prescaler enable
//   i_div_val  in  4  divisor exponent
//   o_tick     out 1  registered wrap strobe
//
// Neither run nor freeze nor clear asserted also clears the counter, so the
// controller only needs to assert run/freeze in the states that keep phase.
// -----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = timer_pkg::PRESCALE_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_freeze,
    input  logic       i_clear,
    input  logic       i_div_en,
    input  logic [3:0] i_div_val,
    output logic       o_tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic [PRESCALE_W-1:0] term;
    logic                  div_en_q;
    div_exp_t              div_val_q;
    logic                  cfg_change;
    logic                  at_term;
    logic                  tick_d;
    logic                  tick_q;

    // Terminal value is a mask of div_val low ones: 2^div_val - 1.
    always_comb begin
        term = '0;
        if (i_div_en) begin
            for (int unsigned i = 0; i < PRESCALE_W; i++) begin
                term[i] = (i < 32'(i_div_val));
            end
        end
    end

    // Any divisor reconfiguration restarts the period from zero so the new
    // divisor takes effect with a full-length first period.
    assign cfg_change = (i_div_en != div_en_q) || (i_div_val != div_val_q);
    assign at_term    = (cnt_q == term);

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (i_clear || cfg_change) begin
            cnt_d = '0;
        end else if (i_run) begin
            if (at_term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else if (i_freeze) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            div_en_q  <= 1'b0;
            div_val_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            div_en_q  <= i_div_en;
            div_val_q <= i_div_val;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/timer_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// timer_cnt_ctrl
// Count-enable controller for the APB timer core. Turns timer enable,
// prescaler settings and the debug-halt handshake into a single-cycle count
// strobe for the 64-bit counter.
//
// Ports:
//   i_clk       in  1  system clock, rising edge
//   i_rst_n     in  1  asynchronous active-low reset
//   i_timer_en  in  1  timer enable (control register)
//   i_div_en    in  1  prescaler enable
//   i_div_val   in  4  divisor exponent, divisor = 2^i_div_val
//   i_halt_req  in  1  debug halt request (level)
//   i_halt_low  in  1  halt request low this and previous cycle (filtered)
//   o_cnt_en    out 1  registered count strobe
//   o_halt_ack  out 1  registered halt acknowledge (high while HALTED)
//   o_div_err   out 1  registered illegal-divisor flag
//
// Build option:
//   TIMER_HALT_SUPPORT_EN  defined   -> full halt handshake with HALTED state
//                          undefined -> halt inputs ignored, o_halt_ack = 0
// -----------------------------------------------------------------------------
module timer_cnt_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = timer_pkg::PRESCALE_W,
    parameter int unsigned MAX_DIV_VAL = timer_pkg::MAX_DIV_VAL
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_timer_en,
    input  logic       i_div_en,
    input  logic [3:0] i_div_val,
    input  logic       i_halt_req,
    input  logic       i_halt_low,
    output logic       o_cnt_en,
    output logic       o_halt_ack,
    output logic       o_div_err
);

    cnt_ctrl_state_e state_q;
    cnt_ctrl_state_e state_d;
    logic            div_err_d;
    logic            div_err_q;
    logic            pre_run;
    logic            pre_freeze;
    logic            pre_tick;

    assign div_err_d = div_cfg_illegal(i_div_en, i_div_val, MAX_DIV_VAL);

    // Timer disable dominates every other event, including a halt request.
    always_comb begin
        state_d = state_q;
        if (!i_timer_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
`ifdef TIMER_HALT_SUPPORT_EN
                RUN: begin
                    if (i_halt_req) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    if (i_halt_low) begin
                        state_d = RUN;
                    end
                end
`else
                RUN:    state_d = RUN;
                HALTED: state_d = RUN;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // The prescaler advances on every edge that lands in RUN except the
    // enabling edge out of IDLE. Counting on the resume edge means the cycle
    // that carried the halt request and the resume cycle together make up
    // one running cycle, so strobe spacing across a halt stays at D running
    // cycles. A halt on a tick edge leaves the counter frozen at D-1.
    assign pre_run    = (state_d == RUN) && (state_q != IDLE);
    assign pre_freeze = (state_d == HALTED);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_run     (pre_run),
        .i_freeze  (pre_freeze),
        .i_clear   (div_err_d),
        .i_div_en  (i_div_en),
        .i_div_val (i_div_val),
        .o_tick    (pre_tick)
    );

`ifdef TIMER_HALT_SUPPORT_EN
    logic halt_ack_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            halt_ack_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            halt_ack_q <= (state_d == HALTED);
            div_err_q  <= div_err_d;
        end
    end

    assign o_halt_ack = halt_ack_q;
`else
    logic unused_halt_inputs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_err_q <= div_err_d;
        end
    end

    assign unused_halt_inputs = i_halt_req ^ i_halt_low;
    assign o_halt_ack         = 1'b0;
`endif

    assign o_cnt_en  = pre_tick;
    assign o_div_err = div_err_q;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_cnt_ctrl
// Directed bench for timer_cnt_ctrl. Inputs change 1 time unit after each
// rising edge and outputs are sampled at the same point. i_halt_low is
// produced here the way low_level_detector does it: request low in the
// current and the previous cycle. Expectations follow the build option
// TIMER_HALT_SUPPORT_EN.
// -----------------------------------------------------------------------------
module tb_timer_cnt_ctrl;

`ifdef TIMER_HALT_SUPPORT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic       clk           = 1'b0;
    logic       rst_n         = 1'b0;
    logic       timer_en      = 1'b0;
    logic       div_en        = 1'b0;
    logic [3:0] div_val       = 4'd0;
    logic       halt_req      = 1'b0;
    logic       halt_req_prev = 1'b0;
    logic       halt_low;
    logic       cnt_en;
    logic       halt_ack;
    logic       div_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) halt_req_prev <= halt_req;
    assign halt_low = ~halt_req & ~halt_req_prev;

    timer_cnt_ctrl #(
        .PRESCALE_W  (8),
        .MAX_DIV_VAL (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_timer_en (timer_en),
        .i_div_en   (div_en),
        .i_div_val  (div_val),
        .i_halt_req (halt_req),
        .i_halt_low (halt_low),
        .o_cnt_en   (cnt_en),
        .o_halt_ack (halt_ack),
        .o_div_err  (div_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_cnt, input logic e_ack, input logic e_err);
        chk({tag, ".cnt_en"},   {31'd0, cnt_en},   {31'd0, e_cnt});
        chk({tag, ".halt_ack"}, {31'd0, halt_ack}, {31'd0, e_ack});
        chk({tag, ".div_err"},  {31'd0, div_err},  {31'd0, e_err});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held across edges, timer enabled: everything stays at 0.
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        timer_en = 1'b1;
        step();
        chk_out("reset_en", 1'b0, 1'b0, 1'b0);
        timer_en = 1'b0;
        #3 rst_n = 1'b1;
        step();
        step();
        chk_out("idle", 1'b0, 1'b0, 1'b0);

        // Divisor 1: strobe from the second edge after enable, every cycle.
        timer_en = 1'b1;
        step();
        chk_out("div1_en_edge", 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            step();
            chk_out("div1_run", 1'b1, 1'b0, 1'b0);
        end

        // Divisor 4: one pulse every 4 cycles, first at enable edge + 4.
        timer_en = 1'b0;
        step();
        chk("disable", {31'd0, cnt_en}, 32'd0);
        div_en   = 1'b1;
        div_val  = 4'd2;
        timer_en = 1'b1;
        step();
        chk("div4_en_edge", {31'd0, cnt_en}, 32'd0);
        for (int j = 1; j <= 12; j++) begin
            step();
            chk("div4", {31'd0, cnt_en}, {31'd0, (j % 4) == 0});
        end
        step();
        chk("div4_tail", {31'd0, cnt_en}, 32'd0);

        // Switch to divisor 8 mid-period: next pulse 8 edges after change.
        div_val = 4'd3;
        step();
        chk("div8_chg_edge", {31'd0, cnt_en}, 32'd0);
        for (int j = 1; j <= 16; j++) begin
            step();
            chk("div8", {31'd0, cnt_en}, {31'd0, (j % 8) == 0});
        end
        for (int j = 1; j <= 3; j++) begin
            step();
            chk_out("pre_halt", 1'b0, 1'b0, 1'b0);
        end

        // Halt for 5 sampled cycles with 3 of 8 counts done. Halt build:
        // ack for edges h..h+5, counting resumes at h+6, pulse at h+10.
        // Without halt support: counting continues, pulse at h+4.
        halt_req = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            if (j == 5) halt_req = 1'b0;
            step();
            if (HALT_EN) begin
                chk("halt_cnt_en", {31'd0, cnt_en},   {31'd0, j == 10});
                chk("halt_ack",    {31'd0, halt_ack}, {31'd0, j <= 5});
            end else begin
                chk("nohalt_cnt_en", {31'd0, cnt_en},   {31'd0, j == 4});
                chk("nohalt_ack",    {31'd0, halt_ack}, 32'd0);
            end
        end

        // Divisor exponent 8 is legal, 9 is not.
        div_val = 4'd8;
        step();
        chk_out("div_max_legal", 1'b0, 1'b0, 1'b0);
        div_val = 4'd9;
        step();
        chk_out("div_err_set", 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk_out("div_err_hold", 1'b0, 1'b0, 1'b1);
        end
        div_val = 4'd0;
        step();
        chk_out("div_err_clr", 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk_out("div0_run", 1'b1, 1'b0, 1'b0);
        end

        // Disable together with a halt request: IDLE wins, no ack.
        timer_en = 1'b0;
        halt_req = 1'b1;
        step();
        chk_out("dis_halt", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("dis_halt_hold", 1'b0, 1'b0, 1'b0);
        halt_req = 1'b0;
        timer_en = 1'b1;
        step();
        chk_out("reen_edge", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("reen_run", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while halted (or running without halt support).
        halt_req = 1'b1;
        step();
        chk_out("pre_rst", !HALT_EN, HALT_EN, 1'b0);
        step();
        chk_out("pre_rst_hold", !HALT_EN, HALT_EN, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0);
        halt_req = 1'b0;
        step();
        chk_out("rst_held", 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        step();
        chk_out("post_rst_en_edge", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("post_rst_run", 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
